// File: rtl/pp_accum_24_pkg.sv
// Shared FPU multiply constants, FSM encoding and the 3:2 compressor helper.
package pp_accum_24_pkg;

  localparam int unsigned MANT_W   = 24;
  localparam int unsigned PROD_W   = 2 * MANT_W;
  localparam int unsigned N_ROWS   = MANT_W;
  localparam int unsigned ROW_W    = PROD_W;
  localparam int unsigned PP_BUS_W = N_ROWS * ROW_W;
  localparam int unsigned IDX_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUM  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Redundant (carry-save) form of a partial sum.
  typedef struct packed {
    logic [ROW_W-1:0] sum;
    logic [ROW_W-1:0] carry;
  } csa_t;

  // One 3:2 compressor level; carries past bit ROW_W-1 are dropped (mod 2^48).
  function automatic csa_t csa3(input logic [ROW_W-1:0] a,
                                input logic [ROW_W-1:0] b,
                                input logic [ROW_W-1:0] c);
    csa_t r;
    r.sum   = a ^ b ^ c;
    r.carry = ((a & b) | (a & c) | (b & c)) << 1;
    return r;
  endfunction

endpackage

// File: rtl/pp_accum_24_if.sv
// Partial-product input bus and product output bus, valid/ready on both sides.
interface pp_accum_24_if;
  import pp_accum_24_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [PP_BUS_W-1:0] pp;
  logic                out_valid;
  logic                out_ready;
  logic [PROD_W-1:0]   prod;
  logic                busy;

  modport master (
    output in_valid, pp, out_ready,
    input  in_ready, out_valid, prod, busy
  );

  modport slave (
    input  in_valid, pp, out_ready,
    output in_ready, out_valid, prod, busy
  );

endinterface

// File: rtl/pp_row_adder.sv
// Combinational sum of a group of rows plus the running accumulator.
module pp_row_adder
  import pp_accum_24_pkg::*;
#(
  parameter int unsigned ROWS = 4
) (
  input  logic [ROW_W-1:0]      acc,
  input  logic [ROWS*ROW_W-1:0] rows,
  output logic [ROW_W-1:0]      sum_c
);

  csa_t cs;

  // Carry-save reduction of acc and all rows, then a single carry-propagate add.
  always_comb begin
    cs.sum   = acc;
    cs.carry = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      cs = csa3(cs.sum, cs.carry, rows[r*ROW_W +: ROW_W]);
    end
    sum_c = cs.sum + cs.carry;
  end

endmodule

// File: rtl/pp_accum_24.sv
// Multi-cycle accumulator of the 24-row mantissa partial-product bus.
module pp_accum_24
  import pp_accum_24_pkg::*;
#(
  parameter int unsigned ROWS_PER_CYCLE = 4
) (
  input logic          clk,
  input logic          rst,
  pp_accum_24_if.slave bus
);

  localparam int unsigned R = ROWS_PER_CYCLE;

  // Reject group sizes that do not tile the 24 rows exactly.
  if (R == 0 || (N_ROWS % R) != 0) begin : g_bad_rows
    $error("pp_accum_24: ROWS_PER_CYCLE must divide 24");
  end

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PP_BUS_W-1:0] pp_q, pp_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic [R*ROW_W-1:0]  rows_sel;
  logic [ROW_W-1:0]    sum_c;

  // Pick the current group of rows out of the captured bus.
  always_comb begin
    rows_sel = '0;
    for (int r = 0; r < int'(R); r++) begin
      rows_sel[r*ROW_W +: ROW_W] = pp_q[(int'(idx_q) + r)*ROW_W +: ROW_W];
    end
  end

  pp_row_adder #(.ROWS(R)) u_row_adder (
    .acc   (acc_q),
    .rows  (rows_sel),
    .sum_c (sum_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    pp_d        = pp_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          pp_d       = bus.pp;
          acc_d      = '0;
          idx_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_SUM;
        end
      end
      ST_SUM: begin
        acc_d = sum_c;
        idx_d = idx_q + IDX_W'(R);
        if (idx_q == IDX_W'(N_ROWS - R)) begin
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      pp_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      pp_q        <= pp_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.prod      = acc_q;
  assign bus.busy      = busy_q;

endmodule
